// File: rtl/hex_ascii_tx_sequencer.sv
// hex_ascii_tx_sequencer
//   Prints one DATA_W-bit word as ASCII hex text, one character per
//   valid/ready handshake, most-significant nibble first. Optional "0x"
//   prefix (PREFIX_EN) and CR/LF terminator (EOL_EN).
//
// Ports
//   CLK       system clock, rising edge
//   RST_N     asynchronous active-low reset
//   START     frame request, honoured only while BUSY=0
//   DATA      word to print, captured when START is honoured
//   BUSY      frame in progress
//   DONE      one-cycle pulse after the final character transfer
//   TX_DATA   current ASCII character (registered)
//   TX_VALID  TX_DATA valid, held until TX_READY
//   TX_READY  sink ready
//
// Also holds dc_hex_ascii, the nibble-to-ASCII converter (uppercase A-F).

module dc_hex_ascii (
    input  logic [3:0] nib,
    output logic [7:0] asc
);
    // 'A' (0x41) - 10 = 0x37
    always_comb asc = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
endmodule

module hex_ascii_tx_sequencer #(
    parameter int DATA_W    = 32,
    parameter int PREFIX_EN = 1,
    parameter int EOL_EN    = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [DATA_W-1:0] DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY
);
    localparam int NIB = DATA_W / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, CR, LF, FIN} state_t;

    state_t               state;
    logic [NIB-1:0][3:0]  shadow;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_m1;
    logic [3:0]           nib;
    logic [7:0]           asc;

    assign cnt_m1 = cnt - CW'(1);

    // Converter input is the nibble for the character presented *next*:
    // the top nibble of DATA when a frame starts, the next lower shadow
    // nibble while stepping digits, otherwise the top shadow nibble
    // (used on the PFX1 -> DIGIT step).
    always_comb begin
        nib = shadow[NIB-1];
        if (state == IDLE || state == FIN)
            nib = DATA[DATA_W-1 -: 4];
        else if (state == DIGIT && cnt != '0)
            nib = shadow[cnt_m1];
    end

    dc_hex_ascii u_hex (
        .nib (nib),
        .asc (asc)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            shadow   <= '0;
            cnt      <= '0;
            TX_DATA  <= 8'h00;
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                // FIN behaves like IDLE for START so frames can run back-to-back
                IDLE, FIN: begin
                    state    <= IDLE;
                    TX_VALID <= 1'b0;
                    BUSY     <= 1'b0;
                    if (START) begin
                        shadow   <= DATA;
                        cnt      <= CW'(NIB - 1);
                        BUSY     <= 1'b1;
                        TX_VALID <= 1'b1;
                        if (PREFIX_EN != 0) begin
                            state   <= PFX0;
                            TX_DATA <= 8'h30;
                        end else begin
                            state   <= DIGIT;
                            TX_DATA <= asc;
                        end
                    end
                end
                PFX0: if (TX_READY) begin
                    state   <= PFX1;
                    TX_DATA <= 8'h78;
                end
                PFX1: if (TX_READY) begin
                    state   <= DIGIT;
                    TX_DATA <= asc;
                end
                DIGIT: if (TX_READY) begin
                    if (cnt != '0) begin
                        cnt     <= cnt_m1;
                        TX_DATA <= asc;
                    end else if (EOL_EN != 0) begin
                        state   <= CR;
                        TX_DATA <= 8'h0D;
                    end else begin
                        state    <= FIN;
                        TX_VALID <= 1'b0;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                    end
                end
                CR: if (TX_READY) begin
                    state   <= LF;
                    TX_DATA <= 8'h0A;
                end
                LF: if (TX_READY) begin
                    state    <= FIN;
                    TX_VALID <= 1'b0;
                    BUSY     <= 1'b0;
                    DONE     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hex_ascii_tx_sequencer.sv
// Testbench for hex_ascii_tx_sequencer: directed steps plus a randomized
// back-to-back run, checked against a text-level model of each frame.

module tb_hex_ascii_tx_sequencer;
    typedef logic [7:0] bq_t[$];

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [31:0] DATA;
    logic        BUSY, DONE, TX_VALID, TX_READY;
    logic [7:0]  TX_DATA;

    logic        start2, ready2;
    logic [7:0]  data2;
    logic        busy2, done2, txv2;
    logic [7:0]  txd2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    hex_ascii_tx_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .DATA(DATA),
        .BUSY(BUSY), .DONE(DONE), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY)
    );

    hex_ascii_tx_sequencer #(.DATA_W(8), .PREFIX_EN(0), .EOL_EN(0)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .START(start2), .DATA(data2),
        .BUSY(busy2), .DONE(done2), .TX_DATA(txd2), .TX_VALID(txv2),
        .TX_READY(ready2)
    );

    // ---------------- monitor (samples on the falling edge) ----------------
    logic [7:0] rx[$];
    int  cyc = 0, last_xfer_cyc = -10;
    int  done_cnt = 0, done_gap_err = 0, hold_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (!RST_N) begin
            prev_stall <= 1'b0;
        end else begin
            if (TX_VALID && TX_READY) begin
                rx.push_back(TX_DATA);
                last_xfer_cyc <= cyc;
            end
            if (DONE) begin
                done_cnt <= done_cnt + 1;
                if (cyc != last_xfer_cyc + 1) done_gap_err <= done_gap_err + 1;
            end
            if (prev_stall && (TX_VALID !== 1'b1 || TX_DATA !== prev_data))
                hold_err <= hold_err + 1;
            prev_stall <= TX_VALID && !TX_READY;
            prev_data  <= TX_DATA;
        end
    end

    // ---------------- reference model ----------------
    function automatic bq_t frame(input logic [31:0] w, input int width,
                                  input bit pfx, input bit eol);
        bq_t   q;
        string hx = "0123456789ABCDEF";
        if (pfx) begin q.push_back(8'h30); q.push_back(8'h78); end
        for (int i = width/4 - 1; i >= 0; i--)
            q.push_back(hx[int'((w >> (4*i)) & 32'hF)]);
        if (eol) begin q.push_back(8'h0D); q.push_back(8'h0A); end
        return q;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (DONE !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, DONE, 1'b1);
    endtask

    task automatic cmp_rx(input string tag, input int base, input bq_t exp);
        chk({tag, "_len"}, rx.size() - base, exp.size());
        for (int i = 0; i < exp.size() && base + i < rx.size(); i++)
            chk($sformatf("%s_ch%0d", tag, i), rx[base+i], exp[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bq_t   exp;
        int    base, dbase, gbase, hbase, k, n;
        logic  exp_valid;
        logic [31:0] words[100];

        RST_N = 1'b0; START = 1'b0; DATA = '0; TX_READY = 1'b0;
        start2 = 1'b0; data2 = '0; ready2 = 1'b1;
        repeat (3) step();
        chk("rst_valid", TX_VALID, 0);
        chk("rst_busy",  BUSY, 0);
        chk("rst_done",  DONE, 0);
        chk("rst_data",  TX_DATA, 8'h00);
        chk("rst_valid2", txv2, 0);
        RST_N = 1'b1;
        step();

        // 1: full-rate frame
        exp = frame(32'h1234ABCF, 32, 1, 1);
        START = 1'b1; DATA = 32'h1234ABCF; TX_READY = 1'b1;
        step();
        START = 1'b0; DATA = $urandom;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            chk($sformatf("t1_valid%0d", i), TX_VALID, 1);
            chk($sformatf("t1_ch%0d", i), TX_DATA, exp[i]);
            chk($sformatf("t1_busy%0d", i), BUSY, 1);
        end
        @(negedge CLK);
        chk("t1_done", DONE, 1);
        chk("t1_busy_fin", BUSY, 0);
        chk("t1_valid_fin", TX_VALID, 0);
        @(negedge CLK);
        chk("t1_done_pulse", DONE, 0);
        step();

        // 2: backpressure on the third character
        base = rx.size(); dbase = done_cnt; hbase = hold_err;
        START = 1'b1; DATA = 32'h0; TX_READY = 1'b1;
        step();
        START = 1'b0;
        step(); step();
        TX_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("t2_hold_data%0d", i), TX_DATA, 8'h30);
            chk($sformatf("t2_hold_valid%0d", i), TX_VALID, 1);
        end
        step();
        TX_READY = 1'b1;
        wait_done("t2_done", 50);
        step(); step();
        cmp_rx("t2", base, frame(32'h0, 32, 1, 1));
        chk("t2_done_cnt", done_cnt - dbase, 1);
        chk("t2_hold_err", hold_err - hbase, 0);

        // 3: START while busy is ignored
        base = rx.size(); dbase = done_cnt;
        START = 1'b1; DATA = 32'h12345678;
        step();
        START = 1'b0;
        repeat (4) step();
        START = 1'b1; DATA = 32'hFFFFFFFF;
        step();
        START = 1'b0;
        wait_done("t3_done", 50);
        step(); step();
        cmp_rx("t3", base, frame(32'h12345678, 32, 1, 1));
        chk("t3_done_cnt", done_cnt - dbase, 1);

        // 4: asynchronous reset mid-frame
        base = rx.size(); dbase = done_cnt;
        START = 1'b1; DATA = $urandom;
        step();
        START = 1'b0;
        n = 0;
        while (rx.size() < base + 4 && n < 50) begin step(); n++; end
        chk("t4_four_xfers", rx.size() - base, 4);
        #1 RST_N = 1'b0;
        #1;
        chk("t4_async_valid", TX_VALID, 0);
        chk("t4_async_busy",  BUSY, 0);
        chk("t4_async_data",  TX_DATA, 8'h00);
        chk("t4_async_done",  DONE, 0);
        step(); step();
        RST_N = 1'b1;
        repeat (3) step();
        chk("t4_no_done", done_cnt - dbase, 0);
        base = rx.size();
        START = 1'b1; DATA = 32'hDEADBEEF;
        step();
        START = 1'b0;
        wait_done("t4_done", 50);
        step(); step();
        cmp_rx("t4", base, frame(32'hDEADBEEF, 32, 1, 1));

        // 5: 8-bit, no prefix, no terminator
        start2 = 1'b1; data2 = 8'h0F;
        step();
        start2 = 1'b0;
        @(negedge CLK);
        chk("t5_ch0", txd2, 8'h30);
        chk("t5_v0", txv2, 1);
        chk("t5_busy", busy2, 1);
        @(negedge CLK);
        chk("t5_ch1", txd2, 8'h46);
        chk("t5_v1", txv2, 1);
        @(negedge CLK);
        chk("t5_done", done2, 1);
        chk("t5_vfin", txv2, 0);
        step();

        // 6: START held high, random backpressure, 100 back-to-back frames
        base = rx.size(); dbase = done_cnt; gbase = done_gap_err; hbase = hold_err;
        exp.delete();
        for (int i = 0; i < 100; i++) begin
            bq_t f;
            words[i] = $urandom;
            f = frame(words[i], 32, 1, 1);
            foreach (f[j]) exp.push_back(f[j]);
        end
        k = 0; n = 0; exp_valid = 1'b0;
        START = 1'b1; DATA = words[0]; TX_READY = ($urandom_range(0, 3) != 0);
        while (k < 100 && n < 20000) begin
            step();
            n++;
            if (exp_valid) chk($sformatf("t6_restart%0d", k), TX_VALID, 1);
            exp_valid = 1'b0;
            TX_READY = ($urandom_range(0, 3) != 0);
            if (DONE) begin
                k++;
                if (k < 100) begin
                    DATA = words[k];
                    exp_valid = 1'b1;
                end else begin
                    START = 1'b0;
                end
            end else begin
                DATA = $urandom;
            end
        end
        chk("t6_frames", k, 100);
        step(); step();
        cmp_rx("t6", base, exp);
        chk("t6_done_cnt", done_cnt - dbase, 100);
        chk("t6_done_gap", done_gap_err - gbase, 0);
        chk("t6_hold_err", hold_err - hbase, 0);
        chk("all_done_gap", done_gap_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_ascii_tx_sequencer.md
Name: hex_ascii_tx_sequencer

Overview:
Sequencer that takes one DATA_W-bit word and streams it as ASCII hex text, one character per handshake, to a byte sink such as a UART transmitter. It steps the word's nibbles most-significant first through a DC_HEX_ASCII instance. It can add an optional "0x" prefix and an optional CR/LF terminator. It sits between debug/status logic and the serial TX path.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 4 and at least 4.
PREFIX_EN, 1, 1 = emit "0x" (0x30, 0x78) before the digits.
EOL_EN, 1, 1 = emit CR (0x0D) then LF (0x0A) after the digits.

Ports:
CLK  input  1  system clock; all state on the rising edge.
RST_N  input  1  asynchronous active-low reset.
START  input  1  request to send DATA; sampled only when BUSY=0.
DATA  input  DATA_W  word to print; captured on the cycle START is accepted.
BUSY  output  1  high while a frame is in progress.
DONE  output  1  one-cycle pulse after the last character handshake.
TX_DATA  output  8  current ASCII character.
TX_VALID  output  1  TX_DATA valid; held until accepted.
TX_READY  input  1  sink ready; a transfer occurs when TX_VALID and TX_READY are both high on a rising edge.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - BUSY, DONE, TX_VALID = 0; TX_DATA = 8'h00; FSM = IDLE; nibble counter = 0.
  - Reset mid-frame abandons the frame. No DONE pulse is generated.
- Output registration: TX_DATA, TX_VALID, BUSY and DONE are registered; no combinational path from inputs to outputs.
- Nibble conversion is done by the DC_HEX_ASCII instance:
  - 0–9 → 0x30–0x39.
  - A–F → 0x41–0x46 (uppercase).
- FSM states: IDLE, PFX0, PFX1, DIGIT, CR, LF, FIN.
- IDLE:
  - If START=1, latch DATA into a shadow register and set BUSY=1.
  - Set nibble counter to DATA_W/4-1.
  - Next state is PFX0 if PREFIX_EN, otherwise DIGIT.
  - TX_VALID=1 with the first character on the next cycle, i.e. one cycle of START-to-first-character latency.
- Character states: each state presents its character with TX_VALID=1. The state advances only on a transfer; TX_DATA stays stable while TX_READY=0.
  - PFX0 → PFX1 → DIGIT.
  - DIGIT: output is the shadow nibble [4*cnt+3:4*cnt]. On transfer: if cnt>0, decrement cnt; if cnt=0, go to CR when EOL_EN, else FIN.
  - CR → LF → FIN.
- Back-to-back characters: the next character is presented in the cycle after a transfer with TX_VALID still 1, so TX_READY held high gives one character per clock.
- FIN (one cycle):
  - TX_VALID=0, BUSY=0, DONE=1; next state IDLE.
  - Entry is registered so that DONE is high in the cycle after the final transfer.
- Back-to-back frames: START is honoured in the cycle DONE=1, because BUSY=0 in that cycle. The new frame's first character appears on the following cycle.
- START while BUSY=1 is ignored; the DATA shadow register does not change.
- Frame length: DATA_W/4 + 2*PREFIX_EN + 2*EOL_EN characters (12 for the defaults).
- DATA changing after acceptance has no effect on the frame in progress.
- TX_READY asserted while TX_VALID=0 has no effect.

Test Plan:
1. Defaults, TX_READY=1 constant, START with DATA=32'h1234ABCF → TX_DATA on 12 consecutive cycles starting 1 cycle after START: 30 78 31 32 33 34 41 42 43 46 0D 0A. DONE pulses once, in the cycle after the 0x0A transfer; BUSY=1 throughout the frame.
2. Backpressure: DATA=32'h00000000, TX_READY low for 5 cycles while the 3rd character is presented → TX_DATA held at 0x30 with TX_VALID=1. Exactly 12 characters delivered in total, none dropped or duplicated.
3. START pulsed with DATA=32'hFFFFFFFF mid-frame of DATA=32'h12345678 → ignored; digits remain 31..38 and a single DONE is seen.
4. RST_N pulsed low after 4 transfers → outputs go to 0 immediately (asynchronously) and no DONE occurs. A subsequent START with DATA=32'hDEADBEEF yields 30 78 44 45 41 44 42 45 45 46 0D 0A.
5. DATA_W=8, PREFIX_EN=0, EOL_EN=0, DATA=8'h0F → exactly two characters, 0x30 then 0x46; DONE in the cycle after the second transfer.
6. START held high through DONE → a second frame is accepted in the DONE cycle and TX_VALID rises on the next cycle; random TX_READY over 100 frames is checked against a reference model.
